// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_B0,
        S_B1,
        S_B2,
        S_CHK,
        S_FAIL
    } state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;
    localparam int         DEFAULT_MAX_WORDS = 1024;
    localparam int         WORD_W            = 18;
    localparam int         ADDR_W            = 10;

    // States in which the inter-byte timer is allowed to run.
    function automatic logic in_frame(input state_t s);
        return (s == S_CNT_HI) || (s == S_CNT_LO) || (s == S_B0) ||
               (s == S_B1) || (s == S_B2) || (s == S_CHK);
    endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last restart.
module prog_loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Fires on the cycle whose edge brings the count to TIMEOUT_CYCLES.
    assign expired = enable && !restart && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (restart)
            cnt_d = '0;
        else if (enable && !expired)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/prog_loader.sv
// UART-fed PicoBlaze program loader: parses a framed, checksummed image
// and writes 18-bit instructions into program memory.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter int         MAX_WORDS      = DEFAULT_MAX_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_data,
    output logic [3:0]        mem_we,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t            state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [7:0]        sum_q, sum_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_data_q, mem_data_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [15:0]       count;
    logic              last_word;
    logic              expired;

    prog_loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .restart(rx_valid),
        .enable (in_frame(state_q)),
        .expired(expired)
    );

    // Full 16-bit count is range-checked so oversized frames are rejected
    // rather than silently truncated to the 10-bit address space.
    assign count     = {cnt_hi_q, rx_data};
    assign last_word = ({1'b0, addr_q} == (words_q - 1'b1));

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        words_d     = words_q;
        addr_d      = addr_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        sum_d       = sum_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_we_d    = '0;
        cpu_reset_d = cpu_reset_q;
        done_d      = 1'b0;
        error_d     = error_q;

        if (rx_valid) begin
            unique case (state_q)
                S_IDLE, S_FAIL: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d     = S_CNT_HI;
                        error_d     = 1'b0;
                        sum_d       = '0;
                        cpu_reset_d = 1'b1;
                    end
                end
                S_CNT_HI: begin
                    cnt_hi_d = rx_data;
                    sum_d    = sum_q + rx_data;
                    state_d  = S_CNT_LO;
                end
                S_CNT_LO: begin
                    sum_d = sum_q + rx_data;
                    if (count == 16'd0 || count > MAX_N) begin
                        state_d = S_FAIL;
                        error_d = 1'b1;
                    end else begin
                        words_d = count[ADDR_W:0];
                        addr_d  = '0;
                        state_d = S_B0;
                    end
                end
                S_B0: begin
                    b0_d    = rx_data[1:0];
                    sum_d   = sum_q + rx_data;
                    state_d = S_B1;
                end
                S_B1: begin
                    b1_d    = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = S_B2;
                end
                S_B2: begin
                    sum_d      = sum_q + rx_data;
                    mem_we_d   = '1;
                    mem_addr_d = addr_q;
                    mem_data_d = {b0_q, b1_q, rx_data};
                    if (last_word) begin
                        state_d = S_CHK;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_B0;
                    end
                end
                S_CHK: begin
                    if (rx_data == sum_q) begin
                        done_d      = 1'b1;
                        cpu_reset_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_FAIL;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (expired) begin
            state_d = S_FAIL;
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_hi_q    <= '0;
            words_q     <= '0;
            addr_q      <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            sum_q       <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_we_q    <= '0;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            words_q     <= words_d;
            addr_q      <= addr_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            sum_q       <= sum_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_we_q    <= mem_we_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign mem_we    = mem_we_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-byte vector table plus timeout and
// asynchronous-reset sequences.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [9:0]  mem_addr;
    logic [17:0] mem_data;
    logic [3:0]  mem_we;
    logic        cpu_reset;
    logic        done;
    logic        error;

    prog_loader #(
        .SYNC_BYTE     (8'h55),
        .TIMEOUT_CYCLES(100),
        .MAX_WORDS     (1024)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_we   (mem_we),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [3:0]  we;
        logic [9:0]  addr;
        logic [17:0] data;
        logic        dn;
        logic        er;
        logic        cr;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] wlog[$];
    int          done_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(negedge clk) begin
        if (mem_we != 4'h0) wlog.push_back({mem_we, mem_addr, mem_data});
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic [3:0] we,
                       input logic [9:0] a, input logic [17:0] w,
                       input logic dn, input logic er, input logic cr);
        vec_t x;
        x.v = v; x.d = d; x.we = we; x.addr = a; x.data = w;
        x.dn = dn; x.er = er; x.cr = cr;
        vecs.push_back(x);
    endtask

    // Two-word frame 55,00,02,01,23,45,02,AB,CD,chk, followed by one idle cycle.
    task automatic add_two_word(input logic [7:0] chk, input logic good,
                                input logic [9:0] pa, input logic [17:0] pd);
        add(1, 8'h55, 4'h0, pa, pd, 0, 0, 1);
        add(1, 8'h00, 4'h0, pa, pd, 0, 0, 1);
        add(1, 8'h02, 4'h0, pa, pd, 0, 0, 1);
        add(1, 8'h01, 4'h0, pa, pd, 0, 0, 1);
        add(1, 8'h23, 4'h0, pa, pd, 0, 0, 1);
        add(1, 8'h45, 4'hF, 10'd0, 18'h12345, 0, 0, 1);
        add(1, 8'h02, 4'h0, 10'd0, 18'h12345, 0, 0, 1);
        add(1, 8'hAB, 4'h0, 10'd0, 18'h12345, 0, 0, 1);
        add(1, 8'hCD, 4'hF, 10'd1, 18'h2ABCD, 0, 0, 1);
        add(1, chk,   4'h0, 10'd1, 18'h2ABCD, good, !good, !good);
        add(0, 8'h00, 4'h0, 10'd1, 18'h2ABCD, 0, !good, !good);
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        logic early;

        #2 reset = 1'b1;
        #1;
        check("reset_state", {mem_we, mem_addr, mem_data, done, error, cpu_reset}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        add_two_word(8'hE5, 1'b1, 10'd0, 18'h0);
        add_two_word(8'hE4, 1'b0, 10'd1, 18'h2ABCD);
        add_two_word(8'hE5, 1'b1, 10'd1, 18'h2ABCD);
        // N=1025 is rejected at CNT_LO; a following non-sync byte is ignored.
        add(1, 8'h55, 4'h0, 10'd1, 18'h2ABCD, 0, 0, 1);
        add(1, 8'h04, 4'h0, 10'd1, 18'h2ABCD, 0, 0, 1);
        add(1, 8'h01, 4'h0, 10'd1, 18'h2ABCD, 0, 1, 1);
        add(0, 8'h00, 4'h0, 10'd1, 18'h2ABCD, 0, 1, 1);
        add(1, 8'h12, 4'h0, 10'd1, 18'h2ABCD, 0, 1, 1);
        // Recovery from FAIL with sync-valued payload bytes (checksum wraps to 00).
        add(1, 8'h55, 4'h0, 10'd1, 18'h2ABCD, 0, 0, 1);
        add(1, 8'h00, 4'h0, 10'd1, 18'h2ABCD, 0, 0, 1);
        add(1, 8'h01, 4'h0, 10'd1, 18'h2ABCD, 0, 0, 1);
        add(1, 8'h55, 4'h0, 10'd1, 18'h2ABCD, 0, 0, 1);
        add(1, 8'h55, 4'h0, 10'd1, 18'h2ABCD, 0, 0, 1);
        add(1, 8'h55, 4'hF, 10'd0, 18'h15555, 0, 0, 1);
        add(1, 8'h00, 4'h0, 10'd0, 18'h15555, 1, 0, 0);
        add(0, 8'h00, 4'h0, 10'd0, 18'h15555, 0, 0, 0);

        foreach (vecs[i]) begin
            rx_valid = vecs[i].v;
            rx_data  = vecs[i].d;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {mem_we, mem_addr, mem_data, done, error, cpu_reset},
                  {vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].dn, vecs[i].er, vecs[i].cr});
        end
        rx_valid = 1'b0;

        // Stall after B1: error must appear on exactly the 100th idle edge.
        send(8'h55); send(8'h00); send(8'h01); send(8'h07); send(8'h08);
        early = 1'b0;
        repeat (99) begin
            @(negedge clk);
            if (error) early = 1'b1;
        end
        check("timeout_early", early, 1'b0);
        @(negedge clk);
        check("timeout_fire", {error, cpu_reset, mem_we}, {1'b1, 1'b1, 4'h0});

        // Asynchronous reset during the write cycle of word 0.
        send(8'h55); send(8'h00); send(8'h02); send(8'h01); send(8'h23); send(8'h45);
        check("write_before_reset", {mem_we, mem_data}, {4'hF, 18'h12345});
        reset = 1'b1;
        #1;
        check("async_reset", {mem_we, mem_addr, mem_data, done, error, cpu_reset}, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        wlog.delete();
        done_cnt = 0;
        send(8'h55); send(8'h00); send(8'h02); send(8'h01); send(8'h23);
        send(8'h45); send(8'h02); send(8'hAB); send(8'hCD); send(8'hE5);
        @(negedge clk);
        check("post_reset_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("post_reset_w0", wlog[0], {4'hF, 10'd0, 18'h12345});
            check("post_reset_w1", wlog[1], {4'hF, 10'd1, 18'h2ABCD});
        end
        check("post_reset_done", done_cnt, 1);
        check("post_reset_flags", {error, cpu_reset}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
